// File: rtl/oct_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oct_rr_arbiter_pkg
// Brief    : Shared state encodings and sizes for the 8-way round-robin arbiter.
// Revision : 1.0
// ============================================================================
package oct_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : oct_rr_arbiter_pkg
`default_nettype wire

// File: rtl/oct_rr_arbiter_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Brief    : Combinational round-robin picker: first set bit of mask at or after start.
// Revision : 1.0
// ============================================================================
module rr_pick8
    import oct_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic             any_o
);

    logic [IDX_W:0]   w_inv_shift;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_low;

    // A shift of 8 (start=0) yields zero, so the OR degenerates to a plain copy.
    assign w_inv_shift = (IDX_W+1)'(N_REQ) - {1'b0, start_i};
    assign w_rot       = (mask_i >> start_i) | (mask_i << w_inv_shift);
    assign w_low       = w_rot & (~w_rot + {{(N_REQ-1){1'b0}}, 1'b1});
    assign onehot_o    = (w_low << start_i) | (w_low >> w_inv_shift);
    assign any_o       = |mask_i;

endmodule : rr_pick8
`default_nettype wire

// File: rtl/oct_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oct_rr_arbiter
// Brief    : 8-requester round-robin arbiter with registered one-hot grant and hold limit.
// Revision : 1.0
// ============================================================================
module oct_rr_arbiter
    import oct_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             preempt_o
);

    localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic [IDX_W-1:0] w_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [N_REQ-1:0] w_others;
    logic [N_REQ-1:0] w_pick_mask;
    logic [IDX_W-1:0] w_pick_start;
    logic [N_REQ-1:0] w_pick;
    logic             w_pick_any;
    logic             w_rel_drop;
    logic             w_rel_hold;
    logic             w_release;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) w_owner = w_owner | IDX_W'(i);
        end
    end

    assign w_owner_nxt = w_owner + IDX_W'(1);
    assign w_others    = req_i & ~gnt_q;
    assign w_rel_drop  = ~|(req_i & gnt_q);
    assign w_rel_hold  = (MAX_HOLD != 0) && (hold_q == HOLD_SAT) && (|w_others);
    assign w_release   = done_i | w_rel_drop | w_rel_hold;

    // The released owner is masked out, so it can never win the handover edge.
    assign w_pick_mask  = (state_q == ST_GRANT) ? w_others    : req_i;
    assign w_pick_start = (state_q == ST_GRANT) ? w_owner_nxt : ptr_q;

    rr_pick8 u_pick (
        .mask_i   (w_pick_mask),
        .start_i  (w_pick_start),
        .onehot_o (w_pick),
        .any_o    (w_pick_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    gnt_d   = w_pick;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    ptr_d     = w_owner_nxt;
                    hold_d    = '0;
                    preempt_d = w_rel_hold & ~done_i & ~w_rel_drop;
                    if (w_pick_any) begin
                        gnt_d = w_pick;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = w_owner;
    assign gnt_valid_o = (state_q == ST_GRANT);
    assign preempt_o   = preempt_q;

endmodule : oct_rr_arbiter
`default_nettype wire
